// File: rtl/rf_line_capture_if.sv
// Sample/handshake bundle between the ADC front end, the capture stage and the
// input sample FIFO. The capture stage connects through the master modport.
interface rf_line_capture_if #(
  parameter int ADC_WIDTH  = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  adc_valid;
  logic [ADC_WIDTH-1:0]  adc_data;
  logic                  trigger;
  logic                  ready_in;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_last;
  logic                  busy;
  logic                  line_done;
  logic [15:0]           line_count;
  logic [15:0]           drop_count;
  logic                  overflow;
  logic                  retrig_err;

  modport master (
    input  adc_valid, adc_data, trigger, ready_in,
    output out_valid, data_out, out_last, busy, line_done,
           line_count, drop_count, overflow, retrig_err
  );

  modport slave (
    output adc_valid, adc_data, trigger, ready_in,
    input  out_valid, data_out, out_last, busy, line_done,
           line_count, drop_count, overflow, retrig_err
  );
endinterface

// File: rtl/rf_line_capture.sv
// Per-channel capture stage: skips START_DELAY samples after a trigger, then
// forwards SAMPLES_PER_LINE samples as two's complement through a one-entry register.
module rf_line_capture #(
  parameter int ADC_WIDTH        = 12,
  parameter int DATA_WIDTH       = 16,
  parameter int SAMPLES_PER_LINE = 1024,
  parameter int START_DELAY      = 0,
  parameter int CNT_WIDTH        = $clog2(SAMPLES_PER_LINE + START_DELAY + 1)
) (
  input  logic clk,
  input  logic reset,
  rf_line_capture_if.master bus
);

  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(SAMPLES_PER_LINE - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_line_done, w_line_done_nxt;
  logic [15:0]           r_line_count, w_line_count_nxt;
  logic [15:0]           r_drop_count, w_drop_count_nxt;
  logic                  r_overflow, w_overflow_nxt;
  logic                  r_retrig, w_retrig_nxt;

  logic                  w_accept;
  logic [ADC_WIDTH-1:0]  w_conv;
  logic [DATA_WIDTH-1:0] w_sample;

  // Offset-binary to two's complement is an MSB flip; the signed cast sign-extends.
  assign w_accept = r_valid && bus.ready_in;
  assign w_conv   = {~bus.adc_data[ADC_WIDTH-1], bus.adc_data[ADC_WIDTH-2:0]};
  assign w_sample = DATA_WIDTH'($signed(w_conv));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_line_done  <= 1'b0;
      r_line_count <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
      r_retrig     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_valid      <= w_valid_nxt;
      r_data       <= w_data_nxt;
      r_last       <= w_last_nxt;
      r_line_done  <= w_line_done_nxt;
      r_line_count <= w_line_count_nxt;
      r_drop_count <= w_drop_count_nxt;
      r_overflow   <= w_overflow_nxt;
      r_retrig     <= w_retrig_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_valid_nxt      = r_valid;
    w_data_nxt       = r_data;
    w_last_nxt       = r_last;
    w_line_done_nxt  = 1'b0;
    w_line_count_nxt = r_line_count;
    w_drop_count_nxt = r_drop_count;
    w_overflow_nxt   = r_overflow;
    w_retrig_nxt     = r_retrig;

    if (w_accept) w_valid_nxt = 1'b0;
    if (bus.trigger && (r_state != IDLE)) w_retrig_nxt = 1'b1;

    case (r_state)
      IDLE: begin
        if (bus.trigger) begin
          w_cnt_nxt = '0;
          if (START_DELAY > 0) w_state_nxt = DELAY;
          else                 w_state_nxt = CAPTURE;
        end
      end
      DELAY: begin
        if (bus.adc_valid) begin
          if (r_cnt == DELAY_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = CAPTURE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
          end
        end
      end
      CAPTURE: begin
        // A strobe counts toward the line length even when it has to be dropped.
        if (bus.adc_valid) begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
          if (!r_valid || w_accept) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_sample;
            w_last_nxt  = (r_cnt == LAST_IDX);
          end else begin
            if (r_drop_count != 16'hFFFF) w_drop_count_nxt = r_drop_count + 16'd1;
            w_overflow_nxt = 1'b1;
          end
          if (r_cnt == LAST_IDX) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_valid || w_accept) begin
          w_line_done_nxt  = 1'b1;
          w_line_count_nxt = r_line_count + 16'd1;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.out_valid  = r_valid;
  assign bus.data_out   = r_data;
  assign bus.out_last   = r_last;
  assign bus.busy       = (r_state != IDLE);
  assign bus.line_done  = r_line_done;
  assign bus.line_count = r_line_count;
  assign bus.drop_count = r_drop_count;
  assign bus.overflow   = r_overflow;
  assign bus.retrig_err = r_retrig;

endmodule

// File: tb/tb_rf_line_capture.sv
// Bench for rf_line_capture: four differently-parameterised instances exercise
// conversion, start delay, backpressure, retrigger, reset abort, randomised lines and saturation.
module tb_rf_line_capture;

  localparam int SPL8    = 8;
  localparam int SPL_SAT = 65540;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int nPass   = 0;
  int nChecks = 0;

  rf_line_capture_if #(.ADC_WIDTH(12), .DATA_WIDTH(16)) if4 ();
  rf_line_capture_if #(.ADC_WIDTH(12), .DATA_WIDTH(16)) ifd ();
  rf_line_capture_if #(.ADC_WIDTH(12), .DATA_WIDTH(16)) if8 ();
  rf_line_capture_if #(.ADC_WIDTH(12), .DATA_WIDTH(16)) ifs ();

  rf_line_capture #(.SAMPLES_PER_LINE(4), .START_DELAY(0))
    u4 (.clk(clk), .reset(reset), .bus(if4.master));
  rf_line_capture #(.SAMPLES_PER_LINE(8), .START_DELAY(2))
    ud (.clk(clk), .reset(reset), .bus(ifd.master));
  rf_line_capture #(.SAMPLES_PER_LINE(SPL8), .START_DELAY(0))
    u8 (.clk(clk), .reset(reset), .bus(if8.master));
  rf_line_capture #(.SAMPLES_PER_LINE(SPL_SAT), .START_DELAY(0))
    us (.clk(clk), .reset(reset), .bus(ifs.master));

  logic [11:0] dpat [64];
  logic [15:0] obsData [$];
  bit          obsLast [$];
  logic [11:0] sent [$];
  int          doneCnt;

  logic [15:0] expData [$];
  bit          expLast [$];
  int          expDrops, expLines;
  bit          expRetrig, expBusy;

  // Offset-binary code to signed value: subtract mid-scale.
  function automatic logic [15:0] conv(input logic [11:0] a);
    int v;
    v = int'(a) - 2048;
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if4.trigger = 0; if4.adc_valid = 0; if4.adc_data = '0; if4.ready_in = 0;
    ifd.trigger = 0; ifd.adc_valid = 0; ifd.adc_data = '0; ifd.ready_in = 0;
    if8.trigger = 0; if8.adc_valid = 0; if8.adc_data = '0; if8.ready_in = 0;
    ifs.trigger = 0; ifs.adc_valid = 0; ifs.adc_data = '0; ifs.ready_in = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_u8(input logic [63:0] vp, input logic [63:0] rp,
                          input logic [63:0] tp, input int n);
    obsData.delete(); obsLast.delete(); sent.delete(); doneCnt = 0;
    for (int i = 0; i < n; i++) begin
      if8.trigger   = tp[i];
      if8.adc_valid = vp[i];
      if8.ready_in  = rp[i];
      if8.adc_data  = dpat[i];
      if (vp[i]) sent.push_back(dpat[i]);
      if (if8.out_valid && if8.ready_in) begin
        obsData.push_back(if8.data_out);
        obsLast.push_back(if8.out_last);
      end
      tick();
      if (if8.line_done) doneCnt++;
    end
    if8.trigger = 0; if8.adc_valid = 0; if8.ready_in = 0;
  endtask

  // Reference: one-slot output buffer, a line is a trigger followed by SPL8 strobes.
  task automatic model_line(input logic [63:0] vp, input logic [63:0] rp,
                            input logic [63:0] tp, input int n);
    int phase, k;
    bit held, wasHeld, acc, hl;
    logic [15:0] hd;
    phase = 0; k = 0; held = 0; hl = 0; hd = '0;
    expData.delete(); expLast.delete();
    expDrops = 0; expLines = 0; expRetrig = 0;
    for (int i = 0; i < n; i++) begin
      wasHeld = held;
      acc = held && rp[i];
      if (acc) begin
        expData.push_back(hd);
        expLast.push_back(hl);
        held = 0;
      end
      if (phase != 0 && tp[i]) expRetrig = 1;
      case (phase)
        0: if (tp[i]) begin phase = 1; k = 0; end
        1: if (vp[i]) begin
             k++;
             if (!wasHeld || acc) begin
               held = 1; hd = conv(dpat[i]); hl = (k == SPL8);
             end else begin
               expDrops++;
             end
             if (k == SPL8) phase = 2;
           end
        default: if (!held) begin expLines++; phase = 0; end
      endcase
    end
    expBusy = (phase != 0);
  endtask

  task automatic test_reset();
    do_reset();
    nChecks++; if (if8.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", if8.out_valid); else nPass++;
    nChecks++; if (if8.data_out !== 16'h0) $display("[TB] FAIL reset_data_out: got %h expected 0000", if8.data_out); else nPass++;
    nChecks++; if (if8.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", if8.busy); else nPass++;
    nChecks++; if (if8.line_count !== 16'h0) $display("[TB] FAIL reset_line_count: got %h expected 0000", if8.line_count); else nPass++;
    nChecks++; if (if8.drop_count !== 16'h0) $display("[TB] FAIL reset_drop_count: got %h expected 0000", if8.drop_count); else nPass++;
    nChecks++; if ({if8.overflow, if8.retrig_err, if8.out_last, if8.line_done} !== 4'b0)
      $display("[TB] FAIL reset_flags: got %b expected 0000", {if8.overflow, if8.retrig_err, if8.out_last, if8.line_done}); else nPass++;
  endtask

  task automatic test_conversion();
    logic [11:0] vals [4];
    logic [15:0] expv [4];
    vals = '{12'h000, 12'h800, 12'hFFF, 12'h001};
    expv = '{16'hF800, 16'h0000, 16'h07FF, 16'hF801};
    do_reset();
    if4.ready_in = 1; if4.trigger = 1;
    tick();
    if4.trigger = 0;
    for (int i = 0; i < 4; i++) begin
      if4.adc_valid = 1; if4.adc_data = vals[i];
      tick();
      nChecks++; if (if4.out_valid !== 1'b1) $display("[TB] FAIL conv_valid[%0d]: got %b expected 1", i, if4.out_valid); else nPass++;
      nChecks++; if (if4.data_out !== expv[i]) $display("[TB] FAIL conv_data[%0d]: got %h expected %h", i, if4.data_out, expv[i]); else nPass++;
      nChecks++; if (if4.out_last !== (i == 3)) $display("[TB] FAIL conv_last[%0d]: got %b expected %b", i, if4.out_last, (i == 3)); else nPass++;
    end
    if4.adc_valid = 0;
    tick();
    nChecks++; if (if4.line_done !== 1'b1) $display("[TB] FAIL conv_line_done: got %b expected 1", if4.line_done); else nPass++;
    nChecks++; if (if4.line_count !== 16'd1) $display("[TB] FAIL conv_line_count: got %0d expected 1", if4.line_count); else nPass++;
    nChecks++; if (if4.busy !== 1'b0) $display("[TB] FAIL conv_busy: got %b expected 0", if4.busy); else nPass++;
    tick();
    nChecks++; if (if4.line_done !== 1'b0) $display("[TB] FAIL conv_done_pulse: got %b expected 0", if4.line_done); else nPass++;
    nChecks++; if ({if4.overflow, if4.retrig_err, if4.drop_count} !== 18'h0)
      $display("[TB] FAIL conv_no_errors: got %h expected 0", {if4.overflow, if4.retrig_err, if4.drop_count}); else nPass++;
    if4.ready_in = 0;
  endtask

  task automatic test_delay();
    logic [15:0] got [$];
    bit          gotLast [$];
    int accCyc, doneCyc, nDone;
    accCyc = -1; doneCyc = -1; nDone = 0;
    do_reset();
    ifd.ready_in = 1;
    for (int i = 0; i < 14; i++) begin
      ifd.trigger   = (i == 0);
      ifd.adc_valid = (i >= 1 && i <= 12);
      ifd.adc_data  = 12'(i - 1);
      if (ifd.out_valid && ifd.ready_in) begin
        got.push_back(ifd.data_out); gotLast.push_back(ifd.out_last); accCyc = i;
      end
      tick();
      if (ifd.line_done) begin nDone++; doneCyc = i + 1; end
    end
    ifd.adc_valid = 0; ifd.ready_in = 0;
    nChecks++; if (got.size() !== 8) $display("[TB] FAIL delay_count: got %0d expected 8", got.size()); else nPass++;
    for (int j = 0; j < got.size() && j < 8; j++) begin
      nChecks++; if (got[j] !== conv(12'(j + 2)) || gotLast[j] !== (j == 7))
        $display("[TB] FAIL delay_sample[%0d]: got %h/%b expected %h/%b", j, got[j], gotLast[j], conv(12'(j + 2)), (j == 7)); else nPass++;
    end
    nChecks++; if (nDone !== 1 || doneCyc !== accCyc + 1)
      $display("[TB] FAIL delay_done_timing: got %0d pulses at %0d expected 1 at %0d", nDone, doneCyc, accCyc + 1); else nPass++;
    nChecks++; if ({ifd.busy, ifd.overflow, ifd.retrig_err, ifd.drop_count} !== 19'h0)
      $display("[TB] FAIL delay_idle_clean: got %h expected 0", {ifd.busy, ifd.overflow, ifd.retrig_err, ifd.drop_count}); else nPass++;
  endtask

  task automatic test_backpressure();
    int idx [6];
    idx = '{0, 1, 4, 5, 6, 7};
    do_reset();
    for (int i = 0; i < 64; i++) dpat[i] = 12'($urandom);
    drive_u8(64'h1FE, ~64'h18, 64'h1, 14);
    nChecks++; if (obsData.size() !== 6) $display("[TB] FAIL bp_count: got %0d expected 6", obsData.size()); else nPass++;
    for (int j = 0; j < obsData.size() && j < 6; j++) begin
      nChecks++; if (obsData[j] !== conv(sent[idx[j]]) || obsLast[j] !== (j == 5))
        $display("[TB] FAIL bp_sample[%0d]: got %h/%b expected %h/%b", j, obsData[j], obsLast[j], conv(sent[idx[j]]), (j == 5)); else nPass++;
    end
    nChecks++; if (if8.drop_count !== 16'd2) $display("[TB] FAIL bp_drop_count: got %0d expected 2", if8.drop_count); else nPass++;
    nChecks++; if (if8.overflow !== 1'b1) $display("[TB] FAIL bp_overflow: got %b expected 1", if8.overflow); else nPass++;
    nChecks++; if (doneCnt !== 1 || if8.line_count !== 16'd1)
      $display("[TB] FAIL bp_line: got %0d pulses count %0d expected 1/1", doneCnt, if8.line_count); else nPass++;
  endtask

  task automatic test_reset_mid_line();
    for (int i = 0; i < 64; i++) dpat[i] = 12'($urandom);
    drive_u8(64'hE, 64'h0, 64'h1, 4);
    nChecks++; if (if8.busy !== 1'b1 || if8.out_valid !== 1'b1)
      $display("[TB] FAIL rst_pre_busy: got %b/%b expected 1/1", if8.busy, if8.out_valid); else nPass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nChecks++; if ({if8.out_valid, if8.busy, if8.out_last, if8.line_done, if8.overflow, if8.retrig_err} !== 6'b0)
      $display("[TB] FAIL rst_flags: got %b expected 000000", {if8.out_valid, if8.busy, if8.out_last, if8.line_done, if8.overflow, if8.retrig_err}); else nPass++;
    nChecks++; if ({if8.data_out, if8.line_count, if8.drop_count} !== 48'h0)
      $display("[TB] FAIL rst_values: got %h expected 0", {if8.data_out, if8.line_count, if8.drop_count}); else nPass++;
    for (int i = 0; i < 64; i++) dpat[i] = 12'($urandom);
    drive_u8(64'h1FE, ~64'h0, 64'h1, 12);
    nChecks++; if (obsData.size() !== 8 || doneCnt !== 1 || if8.line_count !== 16'd1)
      $display("[TB] FAIL rst_fresh_line: got %0d outputs %0d pulses expected 8/1", obsData.size(), doneCnt); else nPass++;
    for (int j = 0; j < obsData.size() && j < 8; j++) begin
      nChecks++; if (obsData[j] !== conv(sent[j]))
        $display("[TB] FAIL rst_fresh_sample[%0d]: got %h expected %h", j, obsData[j], conv(sent[j])); else nPass++;
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    for (int i = 0; i < 64; i++) dpat[i] = 12'($urandom);
    drive_u8(64'h1FE, ~64'h0, 64'h11, 12);
    nChecks++; if (if8.retrig_err !== 1'b1) $display("[TB] FAIL retrig_flag: got %b expected 1", if8.retrig_err); else nPass++;
    nChecks++; if (obsData.size() !== SPL8) $display("[TB] FAIL retrig_count: got %0d expected %0d", obsData.size(), SPL8); else nPass++;
    for (int j = 0; j < obsData.size() && j < SPL8; j++) begin
      nChecks++; if (obsData[j] !== conv(sent[j]) || obsLast[j] !== (j == SPL8 - 1))
        $display("[TB] FAIL retrig_sample[%0d]: got %h/%b expected %h/%b", j, obsData[j], obsLast[j], conv(sent[j]), (j == SPL8 - 1)); else nPass++;
    end
    nChecks++; if (doneCnt !== 1 || if8.line_count !== 16'd1 || if8.busy !== 1'b0)
      $display("[TB] FAIL retrig_line: got %0d pulses count %0d busy %b expected 1/1/0", doneCnt, if8.line_count, if8.busy); else nPass++;
  endtask

  task automatic test_random();
    logic [63:0] vp, rp, tp;
    logic [63:0] mask;
    mask = 64'h0003FFFFFFFFFFFF;
    for (int l = 0; l < 10; l++) begin
      do_reset();
      for (int i = 0; i < 64; i++) dpat[i] = 12'($urandom);
      vp = {32'($urandom), 32'($urandom)} & mask;
      if (l % 3 == 0)      rp = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
      else if (l % 3 == 1) rp = {32'($urandom), 32'($urandom)} | {32'($urandom), 32'($urandom)};
      else                 rp = {32'($urandom), 32'($urandom)};
      rp = (rp & mask) | ~mask;
      tp = 64'h1;
      if ($urandom_range(0, 1) == 1) tp[$urandom_range(1, 49)] = 1'b1;
      model_line(vp, rp, tp, 64);
      drive_u8(vp, rp, tp, 64);
      nChecks++; if (obsData.size() !== expData.size())
        $display("[TB] FAIL rnd%0d_count: got %0d expected %0d", l, obsData.size(), expData.size()); else nPass++;
      for (int j = 0; j < obsData.size() && j < expData.size(); j++) begin
        nChecks++; if (obsData[j] !== expData[j] || obsLast[j] !== expLast[j])
          $display("[TB] FAIL rnd%0d_sample[%0d]: got %h/%b expected %h/%b", l, j, obsData[j], obsLast[j], expData[j], expLast[j]); else nPass++;
      end
      nChecks++; if (if8.drop_count !== 16'(expDrops) || if8.overflow !== (expDrops > 0))
        $display("[TB] FAIL rnd%0d_drops: got %0d/%b expected %0d/%b", l, if8.drop_count, if8.overflow, expDrops, (expDrops > 0)); else nPass++;
      nChecks++; if (if8.line_count !== 16'(expLines) || doneCnt !== expLines)
        $display("[TB] FAIL rnd%0d_lines: got %0d/%0d expected %0d", l, if8.line_count, doneCnt, expLines); else nPass++;
      nChecks++; if (if8.retrig_err !== expRetrig || if8.busy !== expBusy)
        $display("[TB] FAIL rnd%0d_flags: got %b/%b expected %b/%b", l, if8.retrig_err, if8.busy, expRetrig, expBusy); else nPass++;
    end
  endtask

  task automatic test_saturation();
    logic [11:0] first;
    bit seen;
    do_reset();
    ifs.trigger = 1;
    tick();
    ifs.trigger = 0; ifs.ready_in = 0; ifs.adc_valid = 1;
    first = 12'($urandom);
    for (int i = 0; i < SPL_SAT; i++) begin
      ifs.adc_data = (i == 0) ? first : 12'($urandom);
      tick();
      if (i == 100) begin
        nChecks++; if (ifs.drop_count !== 16'd100) $display("[TB] FAIL sat_partial: got %0d expected 100", ifs.drop_count); else nPass++;
      end
      if (i == 65535) begin
        nChecks++; if (ifs.drop_count !== 16'hFFFF) $display("[TB] FAIL sat_reach: got %h expected ffff", ifs.drop_count); else nPass++;
      end
    end
    ifs.adc_valid = 0;
    nChecks++; if (ifs.drop_count !== 16'hFFFF || ifs.overflow !== 1'b1)
      $display("[TB] FAIL sat_hold: got %h/%b expected ffff/1", ifs.drop_count, ifs.overflow); else nPass++;
    nChecks++; if (ifs.out_valid !== 1'b1 || ifs.data_out !== conv(first) || ifs.out_last !== 1'b0 || ifs.busy !== 1'b1)
      $display("[TB] FAIL sat_held: got %b %h %b %b expected 1 %h 0 1", ifs.out_valid, ifs.data_out, ifs.out_last, ifs.busy, conv(first)); else nPass++;
    ifs.ready_in = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (ifs.line_done) seen = 1;
    end
    ifs.ready_in = 0;
    nChecks++; if (!seen || ifs.line_count !== 16'd1 || ifs.retrig_err !== 1'b0)
      $display("[TB] FAIL sat_line_done: got seen=%b count=%0d retrig=%b expected 1/1/0", seen, ifs.line_count, ifs.retrig_err); else nPass++;
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_conversion();
    test_delay();
    test_backpressure();
    test_reset_mid_line();
    test_retrigger();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
